// File: rtl/regfile_2r1w.sv
// regfile_2r1w
// ----------------------------------------------------------------------------
// Register file with 2**AW entries of DW bits. It has one write port and two
// independent read ports, both registered. Each entry has its own clear input
// and valid flag. A sequential clear-all sweep engine clears one entry per
// cycle. An optional write-first bypass lets a read return the value that is
// being written or cleared on the same edge.
//
// Ports
//   clk      in   1    rising-edge clock
//   rst      in   1    synchronous active-high reset, overrides everything
//   we       in   1    write enable (discarded while busy)
//   waddr    in   AW   write address
//   wdata    in   DW   write data
//   clr      in   N    per-entry clear, bit i clears entry i
//   clr_all  in   1    start a clear-all sweep (only accepted when idle)
//   raddr_a  in   AW   read address, port A
//   raddr_b  in   AW   read address, port B
//   rdata_a  out  DW   read data A, one cycle after raddr_a
//   rdata_b  out  DW   read data B, one cycle after raddr_b
//   vld      out  N    vld[i]=1 when entry i was written since its last clear
//   busy     out  1    high while the sweep runs (exactly N cycles)
//   wr_drop  out  1    one-cycle pulse after a write was discarded due to busy
// ----------------------------------------------------------------------------
module regfile_2r1w #(
    parameter int unsigned   AW     = 2,
    parameter int unsigned   DW     = 8,
    parameter logic [DW-1:0] IV     = {DW{1'b0}},
    parameter bit            BYPASS = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [DW-1:0]       wdata,
    input  logic [(2**AW)-1:0]  clr,
    input  logic                clr_all,
    input  logic [AW-1:0]       raddr_a,
    input  logic [AW-1:0]       raddr_b,
    output logic [DW-1:0]       rdata_a,
    output logic [DW-1:0]       rdata_b,
    output logic [(2**AW)-1:0]  vld,
    output logic                busy,
    output logic                wr_drop
);

    localparam int unsigned   N        = 2**AW;
    localparam logic [AW-1:0] IDX_LAST = AW'(N - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    state_t         state_r;
    state_t         state_next_s;
    logic [AW-1:0]  idx_r;
    logic [AW-1:0]  idx_next_s;
    logic           busy_r;
    logic           wr_drop_r;

    logic [DW-1:0]  mem_r      [N];
    logic [DW-1:0]  mem_next_s [N];
    logic [N-1:0]   vld_r;
    logic [N-1:0]   vld_next_s;

    logic [DW-1:0]  rdata_a_r;
    logic [DW-1:0]  rdata_b_r;
    logic [DW-1:0]  rdata_a_next_s;
    logic [DW-1:0]  rdata_b_next_s;

    logic           sweep_s;
    logic           wr_ok_s;

    // Sweep phase decode and write acceptance (writes only land while idle).
    always_comb begin
        sweep_s = (state_r == ST_SWEEP);
        wr_ok_s = we & ~sweep_s;
    end

    // Sweep FSM next state: the idx==N-1 clear is the last one, then exit.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (clr_all) begin
                    state_next_s = ST_SWEEP;
                    idx_next_s   = {AW{1'b0}};
                end else begin
                    state_next_s = ST_IDLE;
                    idx_next_s   = {AW{1'b0}};
                end
            end
            ST_SWEEP: begin
                if (idx_r == IDX_LAST) begin
                    state_next_s = ST_IDLE;
                    idx_next_s   = {AW{1'b0}};
                end else begin
                    state_next_s = ST_SWEEP;
                    idx_next_s   = idx_r + AW'(1);
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                idx_next_s   = {AW{1'b0}};
            end
        endcase
    end

    // Per-entry next value: clear (clr bit or sweep pointer) beats write.
    always_comb begin
        vld_next_s = vld_r;
        for (int i = 0; i < N; i++) begin
            mem_next_s[i] = mem_r[i];
            if (clr[i] || (sweep_s && (idx_r == AW'(i)))) begin
                mem_next_s[i] = IV;
                vld_next_s[i] = 1'b0;
            end else if (wr_ok_s && (waddr == AW'(i))) begin
                mem_next_s[i] = wdata;
                vld_next_s[i] = 1'b1;
            end else begin
                mem_next_s[i] = mem_r[i];
                vld_next_s[i] = vld_r[i];
            end
        end
    end

    // Read mux: bypass selects the post-edge entry image, otherwise the old one.
    always_comb begin
        if (BYPASS) begin
            rdata_a_next_s = mem_next_s[raddr_a];
            rdata_b_next_s = mem_next_s[raddr_b];
        end else begin
            rdata_a_next_s = mem_r[raddr_a];
            rdata_b_next_s = mem_r[raddr_b];
        end
    end

    // Control registers: FSM, sweep index, status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            idx_r     <= {AW{1'b0}};
            busy_r    <= 1'b0;
            wr_drop_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            idx_r     <= idx_next_s;
            busy_r    <= (state_next_s == ST_SWEEP);
            wr_drop_r <= we & sweep_s;
        end
    end

    // Storage, valid flags and registered read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mem_r[i] <= IV;
            end
            vld_r     <= {N{1'b0}};
            rdata_a_r <= IV;
            rdata_b_r <= IV;
        end else begin
            for (int i = 0; i < N; i++) begin
                mem_r[i] <= mem_next_s[i];
            end
            vld_r     <= vld_next_s;
            rdata_a_r <= rdata_a_next_s;
            rdata_b_r <= rdata_b_next_s;
        end
    end

    assign rdata_a = rdata_a_r;
    assign rdata_b = rdata_b_r;
    assign vld     = vld_r;
    assign busy    = busy_r;
    assign wr_drop = wr_drop_r;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: one write-first instance (BYPASS=1) and one
// read-old instance (BYPASS=0) driven by identical stimulus and compared
// against a behavioural model of the register file.
module tb_regfile_2r1w;

    localparam int N = 4;
    localparam logic [7:0] IV = 8'h00;

    logic       clk;
    logic       rst;
    logic       we;
    logic [1:0] waddr;
    logic [7:0] wdata;
    logic [3:0] clr;
    logic       clr_all;
    logic [1:0] raddr_a;
    logic [1:0] raddr_b;
    logic [7:0] rdata_a,  rdata_b,  rdata_a0, rdata_b0;
    logic [3:0] vld,      vld0;
    logic       busy,     busy0;
    logic       wr_drop,  wr_drop0;

    int n_checks;
    int n_errors;

    // model state
    logic [7:0] m_mem [N];
    logic [3:0] m_vld;
    bit         m_active;
    int         m_pos;
    logic [7:0] e_ra, e_rb, e_ra0, e_rb0;
    logic       e_drop;

    regfile_2r1w #(.AW(2), .DW(8), .IV(8'h00), .BYPASS(1'b1)) u_dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .clr(clr), .clr_all(clr_all), .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b), .vld(vld), .busy(busy),
        .wr_drop(wr_drop)
    );

    regfile_2r1w #(.AW(2), .DW(8), .IV(8'h00), .BYPASS(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .clr(clr), .clr_all(clr_all), .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(rdata_a0), .rdata_b(rdata_b0), .vld(vld0), .busy(busy0),
        .wr_drop(wr_drop0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model by one edge using the current inputs, then let the
    // DUTs take the same edge and settle.
    task automatic cycle();
        logic [7:0] nm [N];
        logic [3:0] nv;
        for (int i = 0; i < N; i++) nm[i] = m_mem[i];
        nv = m_vld;
        if (rst) begin
            for (int i = 0; i < N; i++) nm[i] = IV;
            nv = 4'b0000;
            e_ra = IV; e_rb = IV; e_ra0 = IV; e_rb0 = IV;
            e_drop = 1'b0;
            m_active = 1'b0;
            m_pos = 0;
        end else begin
            if (we && !m_active) begin
                nm[waddr] = wdata;
                nv[waddr] = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                if (clr[i] || (m_active && m_pos == i)) begin
                    nm[i] = IV;
                    nv[i] = 1'b0;
                end
            end
            e_ra   = nm[raddr_a];
            e_rb   = nm[raddr_b];
            e_ra0  = m_mem[raddr_a];
            e_rb0  = m_mem[raddr_b];
            e_drop = we && m_active;
            if (m_active) begin
                m_pos++;
                if (m_pos == N) begin
                    m_active = 1'b0;
                    m_pos = 0;
                end
            end else if (clr_all) begin
                m_active = 1'b1;
                m_pos = 0;
            end
        end
        for (int i = 0; i < N; i++) m_mem[i] = nm[i];
        m_vld = nv;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [7:0] d);
        we = 1'b1; waddr = a; wdata = d;
        cycle();
        we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_checks++;
        if (rdata_a !== 8'h00 || rdata_b !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_rdata: got %h/%h expected 00/00", rdata_a, rdata_b);
        end
        n_checks++;
        if (vld !== 4'b0000 || vld0 !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_vld: got %b/%b expected 0000", vld, vld0);
        end
        n_checks++;
        if (busy !== 1'b0 || wr_drop !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_status: got busy=%b wr_drop=%b expected 0/0", busy, wr_drop);
        end
    endtask

    task automatic test_write_read();
        raddr_a = 2'd0; raddr_b = 2'd0;
        do_write(2'd0, 8'h11);
        do_write(2'd1, 8'h22);
        do_write(2'd2, 8'h33);
        do_write(2'd3, 8'h44);
        raddr_a = 2'd2; raddr_b = 2'd3;
        cycle();
        n_checks++;
        if (rdata_a !== 8'h33 || rdata_b !== 8'h44) begin
            n_errors++;
            $display("FAIL write_read: got %h/%h expected 33/44", rdata_a, rdata_b);
        end
        n_checks++;
        if (rdata_a0 !== 8'h33 || rdata_b0 !== 8'h44) begin
            n_errors++;
            $display("FAIL write_read_nobypass: got %h/%h expected 33/44", rdata_a0, rdata_b0);
        end
        n_checks++;
        if (vld !== 4'b1111) begin
            n_errors++;
            $display("FAIL write_vld: got %b expected 1111", vld);
        end
    endtask

    task automatic test_bypass();
        raddr_a = 2'd1;
        we = 1'b1; waddr = 2'd1; wdata = 8'hAA;
        cycle();
        we = 1'b0;
        n_checks++;
        if (rdata_a !== 8'hAA) begin
            n_errors++;
            $display("FAIL bypass_new: got %h expected aa", rdata_a);
        end
        n_checks++;
        if (rdata_a0 !== 8'h22) begin
            n_errors++;
            $display("FAIL nobypass_old: got %h expected 22", rdata_a0);
        end
        cycle();
        n_checks++;
        if (rdata_a0 !== 8'hAA) begin
            n_errors++;
            $display("FAIL nobypass_later: got %h expected aa", rdata_a0);
        end
    endtask

    task automatic test_clear_priority();
        raddr_a = 2'd2;
        clr = 4'b0100;
        we = 1'b1; waddr = 2'd2; wdata = 8'h55;
        cycle();
        clr = 4'b0000; we = 1'b0;
        n_checks++;
        if (rdata_a !== 8'h00 || rdata_a0 !== 8'h33) begin
            n_errors++;
            $display("FAIL clear_vs_write_read: got %h/%h expected 00/33", rdata_a, rdata_a0);
        end
        n_checks++;
        if (vld !== 4'b1011) begin
            n_errors++;
            $display("FAIL clear_vld: got %b expected 1011", vld);
        end
        cycle();
        n_checks++;
        if (rdata_a !== 8'h00 || rdata_a0 !== 8'h00) begin
            n_errors++;
            $display("FAIL clear_entry: got %h/%h expected 00/00", rdata_a, rdata_a0);
        end
    endtask

    task automatic test_sweep();
        int cnt;
        do_write(2'd2, 8'h66);
        clr_all = 1'b1;
        cycle();
        clr_all = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL sweep_start: got busy=%b expected 1", busy);
        end
        cnt = 0;
        while (busy === 1'b1 && cnt < 20) begin
            raddr_a = 2'(cnt);
            raddr_b = 2'(cnt + 1);
            clr_all = (cnt == 2);
            we = (cnt == 1); waddr = 2'd0; wdata = 8'h77;
            cycle();
            n_checks++;
            if (rdata_a !== e_ra || rdata_b !== e_rb || rdata_a0 !== e_ra0 || rdata_b0 !== e_rb0) begin
                n_errors++;
                $display("FAIL sweep_read_%0d: got %h %h %h %h expected %h %h %h %h", cnt,
                         rdata_a, rdata_b, rdata_a0, rdata_b0, e_ra, e_rb, e_ra0, e_rb0);
            end
            n_checks++;
            if (vld !== m_vld) begin
                n_errors++;
                $display("FAIL sweep_vld_%0d: got %b expected %b", cnt, vld, m_vld);
            end
            if (cnt == 1) begin
                n_checks++;
                if (wr_drop !== 1'b1) begin
                    n_errors++;
                    $display("FAIL sweep_wr_drop: got %b expected 1", wr_drop);
                end
            end
            cnt++;
        end
        we = 1'b0; clr_all = 1'b0;
        n_checks++;
        if (cnt != 4) begin
            n_errors++;
            $display("FAIL sweep_length: got %0d expected 4", cnt);
        end
        n_checks++;
        if (vld !== 4'b0000 || wr_drop !== 1'b0) begin
            n_errors++;
            $display("FAIL sweep_end: got vld=%b wr_drop=%b expected 0000/0", vld, wr_drop);
        end
        raddr_a = 2'd0; raddr_b = 2'd3;
        cycle();
        n_checks++;
        if (rdata_a !== 8'h00 || rdata_b !== 8'h00) begin
            n_errors++;
            $display("FAIL sweep_contents: got %h/%h expected 00/00", rdata_a, rdata_b);
        end
    endtask

    task automatic test_sweep_reset();
        for (int i = 0; i < N; i++) do_write(2'(i), 8'(8'hA0 + i));
        clr_all = 1'b1;
        cycle();
        clr_all = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || vld !== 4'b0000) begin
            n_errors++;
            $display("FAIL sweep_abort: got busy=%b vld=%b expected 0/0000", busy, vld);
        end
        for (int p = 0; p < 2; p++) begin
            raddr_a = 2'(2 * p); raddr_b = 2'(2 * p + 1);
            cycle();
            n_checks++;
            if (rdata_a !== IV || rdata_b !== IV || busy !== 1'b0) begin
                n_errors++;
                $display("FAIL sweep_abort_entries_%0d: got %h/%h busy=%b expected 00/00 0",
                         p, rdata_a, rdata_b, busy);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            rst     = ($urandom_range(0, 49) == 0);
            we      = $urandom_range(0, 1);
            waddr   = 2'($urandom);
            wdata   = 8'($urandom);
            clr     = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
            clr_all = ($urandom_range(0, 15) == 0);
            raddr_a = 2'($urandom);
            raddr_b = 2'($urandom);
            cycle();
            n_checks++;
            if (rdata_a !== e_ra || rdata_b !== e_rb) begin
                n_errors++;
                $display("FAIL rand_read_%0d: got %h/%h expected %h/%h", k, rdata_a, rdata_b, e_ra, e_rb);
            end
            n_checks++;
            if (rdata_a0 !== e_ra0 || rdata_b0 !== e_rb0) begin
                n_errors++;
                $display("FAIL rand_read_old_%0d: got %h/%h expected %h/%h", k, rdata_a0, rdata_b0, e_ra0, e_rb0);
            end
            n_checks++;
            if (vld !== m_vld || vld0 !== m_vld) begin
                n_errors++;
                $display("FAIL rand_vld_%0d: got %b/%b expected %b", k, vld, vld0, m_vld);
            end
            n_checks++;
            if (busy !== m_active || busy0 !== m_active) begin
                n_errors++;
                $display("FAIL rand_busy_%0d: got %b/%b expected %b", k, busy, busy0, m_active);
            end
            n_checks++;
            if (wr_drop !== e_drop || wr_drop0 !== e_drop) begin
                n_errors++;
                $display("FAIL rand_wr_drop_%0d: got %b/%b expected %b", k, wr_drop, wr_drop0, e_drop);
            end
        end
        rst = 1'b0; we = 1'b0; clr = 4'b0000; clr_all = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_active = 1'b0;
        m_pos    = 0;
        m_vld    = 4'b0000;
        rst = 1'b1; we = 1'b0; waddr = 2'd0; wdata = 8'h00;
        clr = 4'b0000; clr_all = 1'b0; raddr_a = 2'd0; raddr_b = 2'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_bypass();
        test_clear_priority();
        test_sweep();
        test_sweep_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
